// File: rtl/ad9783_pkg.sv
// Shared AD9783 SPI definitions: instruction word layout, constants and the
// read-engine state encoding, common to the read and write sequencers.
package ad9783_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int DATA_BITS      = 8;
  localparam int INSTR_RW_BIT   = 15;
  localparam int INSTR_N_MSB    = 14;
  localparam int INSTR_N_LSB    = 13;
  localparam int INSTR_ADDR_MSB = 12;
  localparam int INSTR_ADDR_LSB = 8;

  localparam logic       AD9783_RW_READ    = 1'b1;
  localparam logic [1:0] AD9783_N_ONE_BYTE = 2'b00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // The low byte stays zero: the DAC owns SDO while those bits are clocked.
  function automatic logic [FRAME_BITS-1:0] build_read_instr(input logic [4:0] addr);
    logic [FRAME_BITS-1:0] word;
    word = '0;
    word[INSTR_RW_BIT] = AD9783_RW_READ;
    word[INSTR_N_MSB:INSTR_N_LSB] = AD9783_N_ONE_BYTE;
    word[INSTR_ADDR_MSB:INSTR_ADDR_LSB] = addr;
    return word;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider: emits a tick every CLK_DIV cycles while running and,
// when toggling is enabled, flips SCK on each tick with rise/fall strobes.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggle,
  output logic sck,
  output logic tick,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick     = run && (div_cnt == 8'd0);
  assign sck_rise = tick && toggle && !sck;
  assign sck_fall = tick && toggle && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= RELOAD;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= RELOAD;
      sck     <= 1'b0;
    end else begin
      if (div_cnt == 8'd0) div_cnt <= RELOAD;
      else                 div_cnt <= div_cnt - 8'd1;
      if (tick && toggle) sck <= ~sck;
    end
  end

endmodule

// File: rtl/ad9783_spi_reader.sv
// AD9783 register read engine: sends a one-byte read instruction, captures the
// returned byte from SDO and flags/counts mismatches against an expected value.
module ad9783_spi_reader
  import ad9783_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SCK_IDLE = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rd_trig_in,
  input  logic [4:0] rd_addr_in,
  input  logic [7:0] exp_data_in,
  input  logic       err_clr_in,
  output logic       busy_out,
  output logic       rd_valid_out,
  output logic [7:0] rd_data_out,
  output logic       mismatch_out,
  output logic [7:0] err_cnt_out,
  output logic       spi_scs_out,
  output logic       spi_sck_out,
  output logic       spi_sdo_out,
  input  logic       spi_sdi_in
);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [2:0]            state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] instr;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0]  rx_shift;
  logic [7:0]            exp_lat;
  logic                  sck_level;
  logic                  tick;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  run;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign instr = build_read_instr(rd_addr_in);
  assign run   = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .run      (run),
    .toggle   (state == ST_SHIFT),
    .sck      (sck_level),
    .tick     (tick),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign spi_sck_out = (SCK_IDLE != 0) ? ~sck_level : sck_level;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 5'd0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      exp_lat      <= 8'd0;
      busy_out     <= 1'b0;
      spi_scs_out  <= 1'b1;
      spi_sdo_out  <= 1'b0;
      rd_valid_out <= 1'b0;
      rd_data_out  <= 8'd0;
      mismatch_out <= 1'b0;
      err_cnt_out  <= 8'd0;
    end else begin
      rd_valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_trig_in) begin
            tx_shift    <= {instr[FRAME_BITS-2:0], 1'b0};
            spi_sdo_out <= instr[FRAME_BITS-1];
            exp_lat     <= exp_data_in;
            busy_out    <= 1'b1;
            spi_scs_out <= 1'b0;
            bit_cnt     <= 5'd0;
            rx_shift    <= '0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Only the trailing data byte carries DAC read-back on SDO.
          if (sck_rise && (bit_cnt >= 5'(FRAME_BITS - DATA_BITS)))
            rx_shift <= {rx_shift[DATA_BITS-2:0], spi_sdi_in};
          if (sck_fall) begin
            spi_sdo_out <= tx_shift[FRAME_BITS-1];
            tx_shift    <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == 5'(FRAME_BITS - 1)) state <= ST_HOLD;
            else                               bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            spi_scs_out <= 1'b1;
            busy_out    <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          rd_valid_out <= 1'b1;
          rd_data_out  <= rx_shift;
          mismatch_out <= (rx_shift != exp_lat);
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A clear in the same cycle as a counted mismatch takes priority.
      if (err_clr_in)
        err_cnt_out <= 8'd0;
      else if ((state == ST_DONE) && (rx_shift != exp_lat) && (err_cnt_out != 8'hFF))
        err_cnt_out <= err_cnt_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_ad9783_spi_reader.sv
// Self-checking bench for ad9783_spi_reader: a behavioural AD9783 SPI slave
// plus a scoreboard of expected read results, at CLK_DIV=4 and CLK_DIV=2.
module tb_ad9783_spi_reader;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  data;
    logic        mismatch;
  } exp_t;

  typedef struct {
    logic [15:0] bits;
    logic        hp_ok;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       trig [2];
  logic [4:0] rd_addr;
  logic [7:0] exp_data;
  logic       err_clr;
  logic       sdi;
  logic       busy [2];
  logic       rv   [2];
  logic [7:0] rdd  [2];
  logic       mm   [2];
  logic [7:0] errc [2];
  logic       scs  [2];
  logic       sck  [2];
  logic       sdo  [2];

  int checks;
  int failures;
  int cur_div;
  int err_model [2];
  logic [7:0] model_resp;
  exp_t   exp_q   [$];
  frame_t frame_q [$];

  logic m_scs, m_sck, m_sdo;
  assign m_scs = scs[0] & scs[1];
  assign m_sck = sck[0] | sck[1];
  assign m_sdo = sdo[0] | sdo[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ad9783_spi_reader #(.CLK_DIV(4), .SCK_IDLE(0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rd_trig_in(trig[0]), .rd_addr_in(rd_addr),
    .exp_data_in(exp_data), .err_clr_in(err_clr), .busy_out(busy[0]),
    .rd_valid_out(rv[0]), .rd_data_out(rdd[0]), .mismatch_out(mm[0]),
    .err_cnt_out(errc[0]), .spi_scs_out(scs[0]), .spi_sck_out(sck[0]),
    .spi_sdo_out(sdo[0]), .spi_sdi_in(sdi)
  );

  ad9783_spi_reader #(.CLK_DIV(2), .SCK_IDLE(0)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .rd_trig_in(trig[1]), .rd_addr_in(rd_addr),
    .exp_data_in(exp_data), .err_clr_in(err_clr), .busy_out(busy[1]),
    .rd_valid_out(rv[1]), .rd_data_out(rdd[1]), .mismatch_out(mm[1]),
    .err_cnt_out(errc[1]), .spi_scs_out(scs[1]), .spi_sck_out(sck[1]),
    .spi_sdo_out(sdo[1]), .spi_sdi_in(sdi)
  );

  // DAC model: captures MOSI on SCK rise, drives the response byte after SCK falls.
  initial begin
    logic        in_frame, prev_sck, seen, hp_ok;
    logic [15:0] fbits;
    int          rises, falls, hcnt;
    in_frame = 0; prev_sck = 0; seen = 0; hp_ok = 1;
    fbits = '0; rises = 0; falls = 0; hcnt = 0; sdi = 1'b0;
    forever begin
      @(negedge clk);
      if (m_scs) begin
        if (in_frame && rises == 16) frame_q.push_back('{fbits, hp_ok});
        in_frame = 0; rises = 0; falls = 0; fbits = '0;
        hp_ok = 1; seen = 0; hcnt = 0; sdi = 1'b0; prev_sck = m_sck;
      end else begin
        in_frame = 1;
        hcnt++;
        if (m_sck != prev_sck) begin
          if (seen && hcnt != cur_div) hp_ok = 0;
          hcnt = 0;
          seen = 1;
          if (m_sck) begin
            fbits = {fbits[14:0], m_sdo};
            rises++;
          end else begin
            falls++;
            if (falls >= 8 && falls <= 15) sdi = model_resp[15 - falls];
          end
        end
        prev_sck = m_sck;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [4:0] addr, input logic [7:0] expv,
                               input logic [7:0] resp, input bit glitch, input bit clr_at_done,
                               input int abort_at);
    int   lat, cycles, extra;
    bit   got;
    exp_t e;
    frame_t f;
    cur_div = (which == 1) ? 2 : 4;
    lat = 1 + 34 * cur_div;
    @(negedge clk);
    rd_addr = addr;
    exp_data = expv;
    model_resp = resp;
    trig[which] = 1'b1;
    if (abort_at == 0) exp_q.push_back('{{1'b1, 2'b00, addr, 8'h00}, resp, resp != expv});
    @(posedge clk);
    #1 trig[which] = 1'b0;
    cycles = 0;
    got = 0;
    while (cycles < lat + 50 && !got) begin
      @(posedge clk);
      cycles++;
      #1;
      if (abort_at != 0 && cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_scs", 32'(scs[which]), 32'd1);
        checkOutput("abort_sck", 32'(sck[which]), 32'd0);
        checkOutput("abort_busy", 32'(busy[which]), 32'd0);
        err_model[0] = 0;
        err_model[1] = 0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_frame", 32'(frame_q.size()), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        return;
      end
      trig[which] = glitch && (cycles == 10 || cycles == lat - 1);
      if (trig[which]) begin
        rd_addr = ~addr;
        exp_data = ~expv;
      end
      err_clr = clr_at_done && (cycles == lat - 1);
      if (rv[which]) got = 1;
    end
    trig[which] = 1'b0;
    err_clr = 1'b0;
    checkOutput("latency", got ? 32'(cycles) : 32'd0, 32'(lat));
    e = exp_q.pop_front();
    if (!got) return;
    checkOutput("rd_data", 32'(rdd[which]), 32'(e.data));
    checkOutput("mismatch", 32'(mm[which]), 32'(e.mismatch));
    checkOutput("busy_done", 32'(busy[which]), 32'd0);
    if (clr_at_done) begin
      err_model[0] = 0;
      err_model[1] = 0;
    end else if (e.mismatch && err_model[which] < 255) begin
      err_model[which]++;
    end
    checkOutput("err_cnt", 32'(errc[which]), 32'(err_model[which]));
    checkOutput("frame_avail", 32'(frame_q.size()), 32'd1);
    if (frame_q.size() > 0) begin
      f = frame_q.pop_front();
      checkOutput("mosi_frame", 32'(f.bits), 32'(e.frame));
      checkOutput("sck_half_period", 32'(f.hp_ok), 32'd1);
    end
    if (glitch) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk);
        #1 if (rv[which]) extra++;
      end
      checkOutput("extra_valid", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int vcount;
    logic [7:0] r, x;
    checks = 0; failures = 0; cur_div = 4;
    err_model[0] = 0; err_model[1] = 0;
    rst_n = 1'b0; trig[0] = 1'b0; trig[1] = 1'b0;
    rd_addr = '0; exp_data = '0; err_clr = 1'b0; model_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    vcount = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (rv[0] || rv[1]) vcount++;
    end
    checkOutput("idle_valid", 32'(vcount), 32'd0);
    checkOutput("idle_scs", 32'(scs[0]), 32'd1);
    checkOutput("idle_sck", 32'(sck[0]), 32'd0);
    checkOutput("idle_busy", 32'(busy[0]), 32'd0);
    checkOutput("idle_err", 32'(errc[0]), 32'd0);
    checkOutput("idle_data", 32'(rdd[0]), 32'd0);

    $display("[TB] basic read");
    applyStimulus(0, 5'h02, 8'hA5, 8'hA5, 0, 0, 0);

    $display("[TB] mismatch reads and clear");
    applyStimulus(0, 5'h03, 8'h00, 8'h3C, 0, 0, 0);
    applyStimulus(0, 5'h04, 8'h00, 8'h3C, 0, 0, 0);
    applyStimulus(0, 5'h05, 8'h00, 8'h3C, 0, 0, 0);
    applyStimulus(0, 5'h06, 8'h00, 8'h3C, 0, 1, 0);

    $display("[TB] triggers while busy");
    applyStimulus(0, 5'h0A, 8'h11, 8'h11, 1, 0, 0);
    applyStimulus(0, 5'h15, 8'h70, 8'h77, 0, 0, 0);

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 5'h07, 8'h12, 8'h12, 0, 0, 60);
    checkOutput("post_reset_err", 32'(errc[0]), 32'd0);
    applyStimulus(0, 5'h1F, 8'h5A, 8'h5A, 0, 0, 0);

    $display("[TB] CLK_DIV=2 random reads");
    for (int i = 0; i < 300; i++) begin
      r = 8'($urandom);
      x = ($urandom_range(0, 3) == 0) ? r : 8'($urandom);
      applyStimulus(1, 5'($urandom_range(0, 31)), x, r, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
